// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer: releases per-domain active-low resets in index order,
// waiting on each domain's ready ack. Optional DONE-state ack monitor: RST_SEQ_ACK_MONITOR_EN.
`timescale 1ns/1ps
module rst_sequencer #(
    parameter int  NUM_STAGES     = 4,
    parameter int  HOLD_CYCLES    = 16,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_ready,
    output logic                  fault,
    output logic [IDX_W-1:0]      fault_stage
);

    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic [NUM_STAGES-1:0] stage_rst_n_nxt_s;
    logic                  all_ready_nxt_s;
    logic                  fault_nxt_s;
    logic [IDX_W-1:0]      fault_stage_nxt_s;

    logic                  ack_cur_s;
    logic                  hold_end_s;
    logic                  timeout_s;
    logic                  last_s;
    logic                  monitor_trip_s;
    logic [IDX_W-1:0]      monitor_stage_s;

    assign ack_cur_s  = stage_ack[idx_r];
    assign hold_end_s = (cnt_r == HOLD_LAST);
    assign timeout_s  = (cnt_r == TMO_LAST);
    assign last_s     = (idx_r == IDX_LAST);

`ifdef RST_SEQ_ACK_MONITOR_EN
    function automatic logic [IDX_W-1:0] lowest_zero(input logic [NUM_STAGES-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!v[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign monitor_trip_s  = ~(&stage_ack);
    assign monitor_stage_s = lowest_zero(stage_ack);
`else
    assign monitor_trip_s  = 1'b0;
    assign monitor_stage_s = {IDX_W{1'b0}};
`endif

    // State and datapath registers; rst clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            stage_rst_n <= {NUM_STAGES{1'b0}};
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            stage_rst_n <= stage_rst_n_nxt_s;
            all_ready   <= all_ready_nxt_s;
            fault       <= fault_nxt_s;
            fault_stage <= fault_stage_nxt_s;
        end
    end

    // Next-state logic; an ack on the timeout edge still advances the sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HOLD: begin
                if (hold_end_s) state_nxt_s = ST_WAIT;
                else            state_nxt_s = ST_HOLD;
            end
            ST_WAIT: begin
                if (ack_cur_s)      state_nxt_s = last_s ? ST_DONE : ST_HOLD;
                else if (timeout_s) state_nxt_s = ST_FAULT;
                else                state_nxt_s = ST_WAIT;
            end
            ST_DONE: begin
                if (sw_rst_req)          state_nxt_s = ST_HOLD;
                else if (monitor_trip_s) state_nxt_s = ST_FAULT;
                else                     state_nxt_s = ST_DONE;
            end
            ST_FAULT: begin
                if (sw_rst_req) state_nxt_s = ST_HOLD;
                else            state_nxt_s = ST_FAULT;
            end
            default: state_nxt_s = ST_HOLD;
        endcase
    end

    // Next values of counter, index and the registered outputs.
    always_comb begin
        cnt_nxt_s         = cnt_r;
        idx_nxt_s         = idx_r;
        stage_rst_n_nxt_s = stage_rst_n;
        all_ready_nxt_s   = all_ready;
        fault_nxt_s       = fault;
        fault_stage_nxt_s = fault_stage;
        case (state_r)
            ST_HOLD: begin
                if (hold_end_s) begin
                    stage_rst_n_nxt_s[idx_r] = 1'b1;
                    cnt_nxt_s                = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (ack_cur_s) begin
                    if (last_s) begin
                        all_ready_nxt_s = 1'b1;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                        cnt_nxt_s = {CNT_W{1'b0}};
                    end
                end else if (timeout_s) begin
                    fault_nxt_s       = 1'b1;
                    fault_stage_nxt_s = idx_r;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE, ST_FAULT: begin
                if (sw_rst_req) begin
                    stage_rst_n_nxt_s = {NUM_STAGES{1'b0}};
                    all_ready_nxt_s   = 1'b0;
                    fault_nxt_s       = 1'b0;
                    fault_stage_nxt_s = {IDX_W{1'b0}};
                    idx_nxt_s         = {IDX_W{1'b0}};
                    cnt_nxt_s         = {CNT_W{1'b0}};
                end else if ((state_r == ST_DONE) && monitor_trip_s) begin
                    fault_nxt_s       = 1'b1;
                    all_ready_nxt_s   = 1'b0;
                    fault_stage_nxt_s = monitor_stage_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                stage_rst_n_nxt_s = {NUM_STAGES{1'b0}};
                all_ready_nxt_s   = 1'b0;
                fault_nxt_s       = 1'b0;
                fault_stage_nxt_s = {IDX_W{1'b0}};
                idx_nxt_s         = {IDX_W{1'b0}};
                cnt_nxt_s         = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (NUM_STAGES=4, HOLD_CYCLES=16, TIMEOUT_CYCLES=1024).
`timescale 1ns/1ps
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stage_ack;
    logic       sw_rst_req;
    logic [3:0] stage_rst_n;
    logic       all_ready;
    logic       fault;
    logic [1:0] fault_stage;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_CYCLES   (16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stage_ack  (stage_ack),
        .sw_rst_req (sw_rst_req),
        .stage_rst_n(stage_rst_n),
        .all_ready  (all_ready),
        .fault      (fault),
        .fault_stage(fault_stage)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] rn, input logic ar,
                             input logic f, input logic [1:0] fs);
        check_val({tag, "_rstn"}, stage_rst_n, rn);
        check_val({tag, "_ready"}, all_ready, ar);
        check_val({tag, "_fault"}, fault, f);
        check_val({tag, "_fstage"}, fault_stage, fs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_n;
        rst        = 1'b1;
        stage_ack  = 4'b0000;
        sw_rst_req = 1'b0;

        tick(3);
        check_all("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Normal sequence: each ack sampled two edges after its release.
        for (int e = 1; e <= 72; e++) begin
            tick(1);
            exp_n = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (e >= 16 + 18 * k) exp_n[k] = 1'b1;
            end
            check_val($sformatf("seq_rstn_e%0d", e), stage_rst_n, exp_n);
            check_val($sformatf("seq_ready_e%0d", e), all_ready, (e >= 72));
            if (e == 17 || e == 35 || e == 53 || e == 71) stage_ack[(e - 17) / 18] = 1'b1;
        end
        check_val("seq_fault_e72", fault, 1'b0);

        // Drop ack[1] while in DONE.
        stage_ack[1] = 1'b0;
        tick(1);
`ifdef RST_SEQ_ACK_MONITOR_EN
        check_all("mon_trip", 4'b1111, 1'b0, 1'b1, 2'd1);
`else
        check_all("mon_ignore", 4'b1111, 1'b1, 1'b0, 2'd0);
`endif
        tick(2);
`ifdef RST_SEQ_ACK_MONITOR_EN
        check_all("mon_hold", 4'b1111, 1'b0, 1'b1, 2'd1);
`else
        check_all("mon_hold", 4'b1111, 1'b1, 1'b0, 2'd0);
`endif

        // Soft re-sequence from DONE (or FAULT under the monitor build).
        stage_ack  = 4'b0000;
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check_all("sw_clear", 4'b0000, 1'b0, 1'b0, 2'd0);
        tick(15);
        check_val("sw_hold15", stage_rst_n, 4'b0000);
        tick(1);
        check_val("sw_rel0", stage_rst_n, 4'b0001);

        // Soft request in WAIT is ignored.
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check_val("sw_in_wait", stage_rst_n, 4'b0001);
        tick(1);
        check_val("sw_in_wait2", stage_rst_n, 4'b0001);
        stage_ack[0] = 1'b1;
        tick(16);
        check_val("resume_hold", stage_rst_n, 4'b0001);
        tick(1);
        check_val("resume_rel1", stage_rst_n, 4'b0011);

        // Async rst while waiting on stage 1.
        tick(3);
        #2;
        rst       = 1'b1;
        stage_ack = 4'b0000;
        #1;
        check_all("async_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
        tick(2);
        rst = 1'b0;
        tick(15);
        check_val("rst_hold15", stage_rst_n, 4'b0000);
        tick(1);
        check_val("rst_rel0", stage_rst_n, 4'b0001);

        // Ack arriving on the timeout edge wins.
        tick(1023);
        check_all("pre_tmo", 4'b0001, 1'b0, 1'b0, 2'd0);
        stage_ack[0] = 1'b1;
        tick(1);
        check_all("ack_at_tmo", 4'b0001, 1'b0, 1'b0, 2'd0);
        tick(15);
        check_val("adv_hold", stage_rst_n, 4'b0001);
        tick(1);
        check_val("adv_rel1", stage_rst_n, 4'b0011);

        // Stage 2 never acks; ack[3] is asserted but must be ignored.
        stage_ack[3] = 1'b1;
        tick(1);
        stage_ack[1] = 1'b1;
        tick(17);
        check_val("rel2", stage_rst_n, 4'b0111);
        tick(1023);
        check_all("tmo_minus1", 4'b0111, 1'b0, 1'b0, 2'd0);
        tick(1);
        check_all("tmo_fault", 4'b0111, 1'b0, 1'b1, 2'd2);
        tick(5);
        check_all("fault_hold", 4'b0111, 1'b0, 1'b1, 2'd2);

        // Soft re-sequence from FAULT.
        stage_ack  = 4'b0000;
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check_all("fault_clear", 4'b0000, 1'b0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
